id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: one registered output slot holding the decoded instruction, plus a RUN/HALTED state.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: accepts input only when the slot is empty or draining; a load-use hazard or HALT blocks input.
module id_stage #(
    parameter int XLEN         = 32,
    parameter int LU_INTERLOCK = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_class,
    output logic [XLEN-1:0] out_pc,
    output logic            out_alu_en,
    output logic [2:0]      out_alu_oc,
    output logic            out_set_flags,
    output logic [2:0]      out_rd,
    output logic [2:0]      out_rs1,
    output logic [2:0]      out_rs2,
    output logic            out_rd_we,
    output logic            out_rd_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_use_imm,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_branch,
    output logic            out_is_nop,
    output logic            out_illegal,
    output logic [3:0]      out_cond,
    output logic            halted
);

    typedef struct packed {
        logic [1:0]      cls;
        logic [XLEN-1:0] pc;
        logic            alu_en;
        logic [2:0]      alu_oc;
        logic            set_flags;
        logic [2:0]      rd;
        logic [2:0]      rs1;
        logic [2:0]      rs2;
        logic            rd_we;
        logic            rd_rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_nop;
        logic            illegal;
        logic [3:0]      cond;
    } slot_t;

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    slot_t           slot, dec;
    state_t          state, state_nxt;
    logic            live;       // low until the first edge after reset release
    logic            rs1_rd, rs2_rd, is_halt;
    logic            stall, xfer, hazard, alu_code;
    logic [4:0]      op5;
    logic [XLEN-1:0] sx, zx;

    assign op5      = in_instr[29:25];
    assign sx       = XLEN'($signed(in_instr[15:0]));
    assign zx       = XLEN'(in_instr[15:0]);
    // 1x001..1x101: add/sub/and/or/xor, bit 28 selects the flag-setting variant
    assign alu_code = op5[4] && (op5[2:0] != 3'd0) && (op5[2:0] <= 3'd5);

    // Combinational decode of the incoming word; unused fields stay zero
    always_comb begin
        dec         = '0;
        rs1_rd      = 1'b0;
        rs2_rd      = 1'b0;
        is_halt     = 1'b0;
        dec.cls     = in_instr[31:30];
        dec.pc      = in_pc;
        case (in_instr[31:30])
            2'b00: begin
                if (alu_code || (op5[4:3] == 2'b00 && op5[2:0] <= 3'd5)) begin
                    dec.rd_we   = 1'b1;
                    dec.use_imm = 1'b1;
                    dec.rd      = in_instr[24:22];
                    dec.imm     = zx;
                    if (op5[4:1] == 4'b0000) begin
                        dec.rd_rd = op5[0];          // movt keeps the low half of rd
                    end else begin
                        dec.rs1 = in_instr[21:19];
                        rs1_rd  = 1'b1;
                    end
                    if (alu_code) begin
                        dec.alu_en    = 1'b1;
                        dec.alu_oc    = op5[2:0];
                        dec.set_flags = op5[3];
                        if (op5[2:0] == 3'd1 || op5[2:0] == 3'd2) dec.imm = sx;
                    end
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            2'b01: begin
                if (alu_code || op5 == 5'b10110) begin
                    dec.rd_we     = 1'b1;
                    dec.alu_en    = 1'b1;
                    dec.alu_oc    = op5[2:0];
                    dec.set_flags = op5[3];
                    dec.rd        = in_instr[24:22];
                    dec.rs1       = in_instr[21:19];
                    rs1_rd        = 1'b1;
                    if (alu_code) begin
                        dec.rs2 = in_instr[18:16];
                        rs2_rd  = 1'b1;
                    end
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            2'b10: begin
                dec.rd      = in_instr[24:22];
                dec.rs1     = in_instr[21:19];
                rs1_rd      = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = sx;
                dec.is_load = in_instr[25];
                dec.rd_we   = in_instr[25];
                dec.is_store = !in_instr[25];
                dec.rd_rd   = !in_instr[25];     // store data comes from rd
            end
            default: begin
                case (in_instr[28:25])
                    4'b0000: begin
                        dec.is_branch = 1'b1;
                        dec.imm       = sx;
                    end
                    4'b0001: begin
                        dec.is_branch = 1'b1;
                        dec.imm       = sx;
                        dec.cond      = in_instr[24:21];
                    end
                    4'b0010: begin
                        dec.is_branch = 1'b1;
                        dec.rs1       = in_instr[21:19];
                        rs1_rd        = 1'b1;
                    end
                    default: begin
                        if (in_instr[27])      dec.is_nop  = 1'b1;
                        else if (in_instr[28]) is_halt     = 1'b1;
                        else                   dec.illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Load-use check: the incoming word reads the register a held load writes
    always_comb begin
        hazard = (rs1_rd && dec.rs1 == slot.rd) || (rs2_rd && dec.rs2 == slot.rd) ||
                 (dec.rd_rd && dec.rd == slot.rd);
        stall  = (LU_INTERLOCK != 0) && out_valid && slot.is_load && in_valid && hazard;
    end

    assign halted   = (state == HALTED);
    assign in_ready = live && !halted && !flush && (!out_valid || out_ready) && !stall;
    assign xfer     = in_valid && in_ready;

    // Run/halt state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Next state: HALT transfer stops intake, only flush restarts it
    always_comb begin
        state_nxt = state;
        if (flush)                state_nxt = RUN;
        else if (xfer && is_halt) state_nxt = HALTED;
    end

    // Output slot: load on transfer, drain when consumed, squash on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= '0;
            out_valid <= 1'b0;
            live      <= 1'b0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (xfer) begin
                slot      <= dec;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_class     = slot.cls;
    assign out_pc        = slot.pc;
    assign out_alu_en    = slot.alu_en;
    assign out_alu_oc    = slot.alu_oc;
    assign out_set_flags = slot.set_flags;
    assign out_rd        = slot.rd;
    assign out_rs1       = slot.rs1;
    assign out_rs2       = slot.rs2;
    assign out_rd_we     = slot.rd_we;
    assign out_rd_rd     = slot.rd_rd;
    assign out_imm       = slot.imm;
    assign out_use_imm   = slot.use_imm;
    assign out_is_load   = slot.is_load;
    assign out_is_store  = slot.is_store;
    assign out_is_branch = slot.is_branch;
    assign out_is_nop    = slot.is_nop;
    assign out_illegal   = slot.illegal;
    assign out_cond      = slot.cond;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [1:0]  out_class;
    logic        out_alu_en, out_set_flags, out_rd_we, out_rd_rd, out_use_imm;
    logic [2:0]  out_alu_oc, out_rd, out_rs1, out_rs2;
    logic        out_is_load, out_is_store, out_is_branch, out_is_nop, out_illegal, halted;
    logic [3:0]  out_cond;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_instr, b_out_pc, b_out_imm;
    logic [1:0]  b_out_class;
    logic        b_out_alu_en, b_out_set_flags, b_out_rd_we, b_out_rd_rd, b_out_use_imm;
    logic [2:0]  b_out_alu_oc, b_out_rd, b_out_rs1, b_out_rs2;
    logic        b_out_is_load, b_out_is_store, b_out_is_branch, b_out_is_nop, b_out_illegal, b_halted;
    logic [3:0]  b_out_cond;

    int total = 0;
    int bad   = 0;

    id_stage #(.XLEN(32), .LU_INTERLOCK(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_pc(out_pc),
        .out_alu_en(out_alu_en), .out_alu_oc(out_alu_oc), .out_set_flags(out_set_flags),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd_we(out_rd_we), .out_rd_rd(out_rd_rd), .out_imm(out_imm), .out_use_imm(out_use_imm),
        .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_branch(out_is_branch),
        .out_is_nop(out_is_nop), .out_illegal(out_illegal), .out_cond(out_cond), .halted(halted)
    );

    id_stage #(.XLEN(32), .LU_INTERLOCK(0)) dut_nolock (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pc(32'h0), .flush(1'b0),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_class(b_out_class), .out_pc(b_out_pc),
        .out_alu_en(b_out_alu_en), .out_alu_oc(b_out_alu_oc), .out_set_flags(b_out_set_flags),
        .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
        .out_rd_we(b_out_rd_we), .out_rd_rd(b_out_rd_rd), .out_imm(b_out_imm), .out_use_imm(b_out_use_imm),
        .out_is_load(b_out_is_load), .out_is_store(b_out_is_store), .out_is_branch(b_out_is_branch),
        .out_is_nop(b_out_is_nop), .out_illegal(b_out_illegal), .out_cond(b_out_cond), .halted(b_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Offer one word, wait (bounded) for acceptance, leave at 1ns after the transfer edge
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        int n;
        in_valid = 1'b1; in_instr = instr; in_pc = pc; n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL send_accept got=%b exp=1 instr=%h", in_ready, instr); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_instr = 32'h2288FFFF;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_rd !== 3'd0 || out_imm !== 32'd0) begin bad++; $display("FAIL rst_fields got=%0d/%h exp=0/0", out_rd, out_imm); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_rel_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_edge_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        send(32'h2288FFFF, 32'h0000_0100);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        total++; if (out_rd !== 3'd2 || out_rs1 !== 3'd1) begin bad++; $display("FAIL add_regs got=%0d/%0d exp=2/1", out_rd, out_rs1); end
        total++; if (out_alu_oc !== 3'b001 || out_set_flags !== 1'b0 || out_alu_en !== 1'b1) begin bad++; $display("FAIL add_alu got=%b/%b/%b exp=001/0/1", out_alu_oc, out_set_flags, out_alu_en); end
        total++; if (out_imm !== 32'hFFFFFFFF || out_use_imm !== 1'b1) begin bad++; $display("FAIL add_imm got=%h/%b exp=ffffffff/1", out_imm, out_use_imm); end
        total++; if (out_rd_we !== 1'b1 || out_pc !== 32'h100) begin bad++; $display("FAIL add_we_pc got=%b/%h exp=1/100", out_rd_we, out_pc); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_load_use();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h82E00004; in_pc = 32'h200;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_is_load !== 1'b1) begin bad++; $display("FAIL lu_load got=%b/%b exp=1/1", out_valid, out_is_load); end
        total++; if (out_rd !== 3'd3 || out_rs1 !== 3'd4 || out_imm !== 32'd4) begin bad++; $display("FAIL lu_load_fields got=%0d/%0d/%h exp=3/4/4", out_rd, out_rs1, out_imm); end
        in_instr = 32'h62580000; in_pc = 32'h204;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_resume got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_is_load !== 1'b0 || out_alu_en !== 1'b1) begin bad++; $display("FAIL lu_add got=%b/%b/%b exp=1/0/1", out_valid, out_is_load, out_alu_en); end
        total++; if (out_rd !== 3'd1 || out_rs1 !== 3'd3 || out_rs2 !== 3'd0 || out_use_imm !== 1'b0) begin bad++; $display("FAIL lu_add_fields got=%0d/%0d/%0d/%b exp=1/3/0/0", out_rd, out_rs1, out_rs2, out_use_imm); end
        @(posedge clk); #1;
    endtask

    task automatic test_no_interlock();
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_instr = 32'h82E00004;
        @(posedge clk); #1;
        total++; if (b_out_valid !== 1'b1 || b_out_is_load !== 1'b1) begin bad++; $display("FAIL nl_load got=%b/%b exp=1/1", b_out_valid, b_out_is_load); end
        b_in_instr = 32'h62580000;
        @(negedge clk);
        total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL nl_ready got=%b exp=1", b_in_ready); end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        total++; if (b_out_valid !== 1'b1 || b_out_rd !== 3'd1 || b_out_rs1 !== 3'd3 || b_out_is_load !== 1'b0) begin bad++; $display("FAIL nl_add got=%b/%0d/%0d/%b exp=1/1/3/0", b_out_valid, b_out_rd, b_out_rs1, b_out_is_load); end
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        send(32'hC340FFFE, 32'h300);
        total++; if (out_is_branch !== 1'b1 || out_cond !== 4'hA || out_class !== 2'd3) begin bad++; $display("FAIL br_flags got=%b/%h/%0d exp=1/a/3", out_is_branch, out_cond, out_class); end
        total++; if (out_imm !== 32'hFFFFFFFE || out_rd_we !== 1'b0) begin bad++; $display("FAIL br_imm got=%h/%b exp=fffffffe/0", out_imm, out_rd_we); end
        send(32'hC8000000, 32'h304);
        total++; if (out_is_nop !== 1'b1 || out_is_branch !== 1'b0 || out_cond !== 4'h0 || out_imm !== 32'h0) begin bad++; $display("FAIL nop got=%b/%b/%h/%h exp=1/0/0/0", out_is_nop, out_is_branch, out_cond, out_imm); end
    endtask

    task automatic test_decode_misc();
        out_ready = 1'b1;
        send(32'h00F88000, 32'h400);
        total++; if (out_rd !== 3'd3 || out_rs1 !== 3'd0 || out_rd_we !== 1'b1 || out_alu_en !== 1'b0) begin bad++; $display("FAIL mov got=%0d/%0d/%b/%b exp=3/0/1/0", out_rd, out_rs1, out_rd_we, out_alu_en); end
        total++; if (out_imm !== 32'h00008000) begin bad++; $display("FAIL mov_zext got=%h exp=00008000", out_imm); end
        send(32'h2800FFFF, 32'h404);
        total++; if (out_alu_oc !== 3'd4 || out_alu_en !== 1'b1 || out_imm !== 32'h0000FFFF) begin bad++; $display("FAIL or_zext got=%0d/%b/%h exp=4/1/0000ffff", out_alu_oc, out_alu_en, out_imm); end
        send(32'h6C880000, 32'h408);
        total++; if (out_alu_oc !== 3'd6 || out_rs2 !== 3'd0 || out_rd !== 3'd2 || out_rs1 !== 3'd1 || out_use_imm !== 1'b0) begin bad++; $display("FAIL not got=%0d/%0d/%0d/%0d/%b exp=6/0/2/1/0", out_alu_oc, out_rs2, out_rd, out_rs1, out_use_imm); end
        send(32'h7E000000, 32'h40C);
        total++; if (out_illegal !== 1'b1 || out_rd_we !== 1'b0 || out_alu_en !== 1'b0) begin bad++; $display("FAIL illegal got=%b/%b/%b exp=1/0/0", out_illegal, out_rd_we, out_alu_en); end
    endtask

    task automatic test_halt();
        out_ready = 1'b1;
        send(32'hD0000000, 32'h500);
        out_ready = 1'b0;
        total++; if (halted !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL halt_enter got=%b/%b exp=1/1", halted, out_valid); end
        in_valid = 1'b1; in_instr = 32'h2288FFFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++; if (halted !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL halt_hold%0d got=%b/%b exp=1/0", i, halted, in_ready); end
        end
        flush = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        total++; if (halted !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_clear got=%b/%b/%b exp=0/0/1", halted, out_valid, in_ready); end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        send(32'h2288FFFF, 32'h600);
        in_valid = 1'b1; in_instr = 32'h62580000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_rd !== 3'd2 || out_imm !== 32'hFFFFFFFF || out_pc !== 32'h600) begin bad++; $display("FAIL hold%0d got=%b/%0d/%h/%h exp=1/2/ffffffff/600", i, out_valid, out_rd, out_imm, out_pc); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready%0d got=%b exp=0", i, in_ready); end
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_rd !== 3'd0 || out_imm !== 32'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL hold_rst got=%b/%0d/%h/%b exp=0/0/0/0", out_valid, out_rd, out_imm, in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_instr = 32'h0; b_out_ready = 1'b1;
        test_reset();
        test_add();
        test_load_use();
        test_no_interlock();
        test_branch();
        test_decode_misc();
        test_halt();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
